// File: rtl/rename_table_pkg.sv
// Shared types for the register alias table: architectural/ROB identifiers and
// the per-register {spec, tag} mapping entry.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 6
`endif

package rename_table_pkg;

    localparam int ROB_ID_W = `ROB_ID_WIDTH;
    localparam int N_ARCH   = 32;
    localparam int ARF_ID_W = $clog2(N_ARCH);

    typedef logic [ARF_ID_W-1:0] arf_id_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef struct packed {
        logic    spec;
        rob_id_t tag;
    } rat_entry_t;

    localparam arf_id_t    ARF_X0          = '0;
    localparam rat_entry_t RAT_ENTRY_CLEAR = '0;

endpackage

// File: rtl/rat_bypass_sel.sv
// Per-lane, per-source producer select: the youngest older lane in the dispatch
// group that writes this source overrides the table entry; x0 never maps.
module rat_bypass_sel #(
    parameter int LANE = 0,
    parameter int W    = 2,
    parameter int A    = 5,
    parameter int T    = 6
) (
    input  logic [A-1:0]   src,
    input  logic [W-1:0]   wr_en,
    input  logic [W*A-1:0] wr_rd,
    input  logic [W*T-1:0] wr_tag,
    input  logic           tbl_spec,
    input  logic [T-1:0]   tbl_tag,
    output logic           spec,
    output logic [T-1:0]   tag
);

    always_comb begin
        // NOTE: both outputs get a value before any condition, so no latch is inferred.
        spec = tbl_spec;
        tag  = tbl_tag;
        // Ascending scan: a later (younger) matching lane overwrites an earlier one.
        for (int j = 0; j < W; j++) begin
            if (j < LANE && wr_en[j] && wr_rd[j*A +: A] == src) begin
                spec = 1'b1;
                tag  = wr_tag[j*T +: T];
            end
        end
        if (src == '0) begin
            spec = 1'b0;
        end
        // A non-speculative source reports tag 0, hiding stale tags left by flush.
        if (!spec) begin
            tag = '0;
        end
    end

endmodule

// File: rtl/rename_table.sv
// Register alias table: renames DISPATCH_WIDTH instructions per cycle with
// intra-group bypass and clears mappings for up to RETIRE_WIDTH retiring entries.
module rename_table
    import rename_table_pkg::*;
#(
    parameter int DISPATCH_WIDTH = 2,
    parameter int RETIRE_WIDTH   = 2,
    parameter int N_ARCH_REGS    = N_ARCH,
    parameter int ROB_ID_WIDTH   = ROB_ID_W,
    parameter int ARF_ID_WIDTH   = $clog2(N_ARCH_REGS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DISPATCH_WIDTH-1:0]              ren_valid,
    input  logic [DISPATCH_WIDTH*ARF_ID_WIDTH-1:0] ren_rs1,
    input  logic [DISPATCH_WIDTH*ARF_ID_WIDTH-1:0] ren_rs2,
    input  logic [DISPATCH_WIDTH-1:0]              ren_rd_valid,
    input  logic [DISPATCH_WIDTH*ARF_ID_WIDTH-1:0] ren_rd,
    input  logic [DISPATCH_WIDTH*ROB_ID_WIDTH-1:0] ren_rob_id,
    output logic [DISPATCH_WIDTH-1:0]              src1_spec,
    output logic [DISPATCH_WIDTH-1:0]              src2_spec,
    output logic [DISPATCH_WIDTH*ROB_ID_WIDTH-1:0] src1_rob_id,
    output logic [DISPATCH_WIDTH*ROB_ID_WIDTH-1:0] src2_rob_id,
    input  logic [RETIRE_WIDTH-1:0]                ret_valid,
    input  logic [RETIRE_WIDTH*ARF_ID_WIDTH-1:0]   ret_arf_id,
    input  logic [RETIRE_WIDTH*ROB_ID_WIDTH-1:0]   ret_rob_id,
    input  logic                                   flush
);

    localparam int W = DISPATCH_WIDTH;
    localparam int R = RETIRE_WIDTH;
    localparam int A = ARF_ID_WIDTH;
    localparam int T = ROB_ID_WIDTH;

    rat_entry_t       rat_q [N_ARCH_REGS];
    logic [W-1:0]     wr_en;

    assign wr_en = ren_valid & ren_rd_valid;

    for (genvar i = 0; i < W; i++) begin : g_lane
        rat_entry_t ent1;
        rat_entry_t ent2;

        assign ent1 = rat_q[ren_rs1[i*A +: A]];
        assign ent2 = rat_q[ren_rs2[i*A +: A]];

        rat_bypass_sel #(.LANE(i), .W(W), .A(A), .T(T)) u_src1 (
            .src      (ren_rs1[i*A +: A]),
            .wr_en    (wr_en),
            .wr_rd    (ren_rd),
            .wr_tag   (ren_rob_id),
            .tbl_spec (ent1.spec),
            .tbl_tag  (ent1.tag),
            .spec     (src1_spec[i]),
            .tag      (src1_rob_id[i*T +: T])
        );

        rat_bypass_sel #(.LANE(i), .W(W), .A(A), .T(T)) u_src2 (
            .src      (ren_rs2[i*A +: A]),
            .wr_en    (wr_en),
            .wr_rd    (ren_rd),
            .wr_tag   (ren_rob_id),
            .tbl_spec (ent2.spec),
            .tbl_tag  (ent2.tag),
            .spec     (src2_spec[i]),
            .tag      (src2_rob_id[i*T +: T])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is reset in full because tags must read 0 after reset.
            for (int r = 0; r < N_ARCH_REGS; r++) begin
                rat_q[r] <= RAT_ENTRY_CLEAR;
            end
        end else if (flush) begin
            for (int r = 0; r < N_ARCH_REGS; r++) begin
                rat_q[r].spec <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking updates mean the retire tag compare sees start-of-cycle
            // state, and the rename writes issued after it win on the same register.
            for (int j = 0; j < R; j++) begin
                if (ret_valid[j] && ret_arf_id[j*A +: A] != ARF_X0 &&
                    rat_q[ret_arf_id[j*A +: A]].tag == ret_rob_id[j*T +: T]) begin
                    rat_q[ret_arf_id[j*A +: A]].spec <= 1'b0;
                end
            end
            for (int i = 0; i < W; i++) begin
                if (wr_en[i] && ren_rd[i*A +: A] != ARF_X0) begin
                    rat_q[ren_rd[i*A +: A]] <= '{spec: 1'b1, tag: ren_rob_id[i*T +: T]};
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_table.sv
// Self-checking bench for rename_table: directed cases with literal expectations
// plus an array-based reference model compared on every cycle.
module tb_rename_table;
    import rename_table_pkg::*;

    localparam int W  = 2;
    localparam int R  = 2;
    localparam int A  = ARF_ID_W;
    localparam int T  = ROB_ID_W;
    localparam int NR = N_ARCH;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [W-1:0]   ren_valid, ren_rd_valid, src1_spec, src2_spec;
    logic [W*A-1:0] ren_rs1, ren_rs2, ren_rd;
    logic [W*T-1:0] ren_rob_id, src1_rob_id, src2_rob_id;
    logic [R-1:0]   ret_valid;
    logic [R*A-1:0] ret_arf_id;
    logic [R*T-1:0] ret_rob_id;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    bit          m_spec [NR];
    int unsigned m_tag  [NR];

    always #5 clk = ~clk;

    rename_table dut (
        .clk          (clk),
        .rst          (rst),
        .ren_valid    (ren_valid),
        .ren_rs1      (ren_rs1),
        .ren_rs2      (ren_rs2),
        .ren_rd_valid (ren_rd_valid),
        .ren_rd       (ren_rd),
        .ren_rob_id   (ren_rob_id),
        .src1_spec    (src1_spec),
        .src2_spec    (src2_spec),
        .src1_rob_id  (src1_rob_id),
        .src2_rob_id  (src2_rob_id),
        .ret_valid    (ret_valid),
        .ret_arf_id   (ret_arf_id),
        .ret_rob_id   (ret_rob_id),
        .flush        (flush)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural map updated from the rules at each edge.
    always @(posedge clk) begin
        bit          nspec [NR];
        int unsigned ntag  [NR];
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_spec[r] = 1'b0;
                m_tag[r]  = 0;
            end
        end else if (flush) begin
            for (int r = 0; r < NR; r++) m_spec[r] = 1'b0;
        end else begin
            nspec = m_spec;
            ntag  = m_tag;
            for (int j = 0; j < R; j++) begin
                int a;
                a = int'(ret_arf_id[j*A +: A]);
                if (ret_valid[j] && a != 0 && m_tag[a] == ret_rob_id[j*T +: T])
                    nspec[a] = 1'b0;
            end
            for (int i = 0; i < W; i++) begin
                int d;
                d = int'(ren_rd[i*A +: A]);
                if (ren_valid[i] && ren_rd_valid[i] && d != 0) begin
                    nspec[d] = 1'b1;
                    ntag[d]  = ren_rob_id[i*T +: T];
                end
            end
            m_spec = nspec;
            m_tag  = ntag;
        end
    end

    function automatic void exp_src(input int lane, input int s,
                                    output bit sp, output int unsigned tg);
        sp = 1'b0;
        tg = 0;
        if (s == 0) return;
        for (int j = lane - 1; j >= 0; j--) begin
            if (ren_valid[j] && ren_rd_valid[j] && int'(ren_rd[j*A +: A]) == s) begin
                sp = 1'b1;
                tg = ren_rob_id[j*T +: T];
                return;
            end
        end
        sp = m_spec[s];
        tg = sp ? m_tag[s] : 0;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < W; i++) begin
                bit          sp;
                int unsigned tg;
                if (ren_valid[i]) begin
                    exp_src(i, int'(ren_rs1[i*A +: A]), sp, tg);
                    check($sformatf("model src1_spec[%0d]", i), src1_spec[i], sp);
                    check($sformatf("model src1_tag[%0d]", i), src1_rob_id[i*T +: T], tg);
                    exp_src(i, int'(ren_rs2[i*A +: A]), sp, tg);
                    check($sformatf("model src2_spec[%0d]", i), src2_spec[i], sp);
                    check($sformatf("model src2_tag[%0d]", i), src2_rob_id[i*T +: T], tg);
                end
            end
        end
    end

    task automatic clear_inputs();
        ren_valid    = '0;
        ren_rd_valid = '0;
        ren_rs1      = '0;
        ren_rs2      = '0;
        ren_rd       = '0;
        ren_rob_id   = '0;
        ret_valid    = '0;
        ret_arf_id   = '0;
        ret_rob_id   = '0;
        flush        = 1'b0;
    endtask

    task automatic set_ren(input int lane, input int rs1, input int rs2,
                           input bit rdv, input int rd, input int tag);
        ren_valid[lane]          = 1'b1;
        ren_rs1[lane*A +: A]     = A'(rs1);
        ren_rs2[lane*A +: A]     = A'(rs2);
        ren_rd_valid[lane]       = rdv;
        ren_rd[lane*A +: A]      = A'(rd);
        ren_rob_id[lane*T +: T]  = T'(tag);
    endtask

    task automatic set_ret(input int lane, input int arf, input int tag);
        ret_valid[lane]          = 1'b1;
        ret_arf_id[lane*A +: A]  = A'(arf);
        ret_rob_id[lane*T +: T]  = T'(tag);
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic chk1(input string name, input int lane, input bit sp, input int tg);
        check({name, " spec1"}, src1_spec[lane], sp);
        check({name, " tag1"}, src1_rob_id[lane*T +: T], tg);
    endtask

    task automatic chk2(input string name, input int lane, input bit sp, input int tg);
        check({name, " spec2"}, src2_spec[lane], sp);
        check({name, " tag2"}, src2_rob_id[lane*T +: T], tg);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;

        // After reset: everything reads from the ARF.
        set_ren(0, 5, 0, 1'b0, 0, 0);
        settle();
        chk1("reset r5", 0, 1'b0, 0);
        chk2("reset x0", 0, 1'b0, 0);
        next_cycle();

        // Intra-group bypass of r3 -> tag 7.
        set_ren(0, 1, 2, 1'b1, 3, 7);
        set_ren(1, 3, 0, 1'b0, 0, 0);
        settle();
        chk1("bypass r3", 1, 1'b1, 7);
        next_cycle();

        // Table now holds r3 -> 7; rename r3 again to tag 9.
        set_ren(0, 0, 3, 1'b1, 3, 9);
        settle();
        chk2("table r3", 0, 1'b1, 7);
        next_cycle();

        // Stale retire of tag 7 must not clear r3.
        set_ren(0, 3, 0, 1'b0, 0, 0);
        set_ret(0, 3, 7);
        settle();
        chk1("renamed r3", 0, 1'b1, 9);
        next_cycle();

        set_ren(0, 3, 0, 1'b0, 0, 0);
        set_ret(1, 3, 9);
        settle();
        chk1("stale retire r3", 0, 1'b1, 9);
        next_cycle();

        set_ren(0, 3, 0, 1'b0, 0, 0);
        settle();
        chk1("retired r3", 0, 1'b0, 0);
        next_cycle();

        // Both lanes write r6; lane 1 bypasses from lane 0, highest lane wins.
        set_ren(0, 0, 0, 1'b1, 6, 1);
        set_ren(1, 6, 0, 1'b1, 6, 2);
        settle();
        chk1("dual rd r6 bypass", 1, 1'b1, 1);
        next_cycle();

        set_ren(0, 6, 0, 1'b1, 4, 5);
        settle();
        chk1("dual rd r6 winner", 0, 1'b1, 2);
        next_cycle();

        // Retire r4/5 and rename r4/2 together; lane 0 renames x0.
        set_ret(0, 4, 5);
        set_ren(0, 0, 0, 1'b1, 0, 3);
        set_ren(1, 0, 4, 1'b1, 4, 2);
        settle();
        chk1("x0 no bypass", 1, 1'b0, 0);
        chk2("r4 pre", 1, 1'b1, 5);
        next_cycle();

        set_ren(0, 4, 0, 1'b0, 0, 0);
        settle();
        chk1("rename beats retire", 0, 1'b1, 2);
        chk2("x0 after rd0", 0, 1'b0, 0);
        next_cycle();

        // Populate more mappings, then flush alongside a rename of r8.
        set_ren(0, 0, 0, 1'b1, 8, 10);
        set_ren(1, 0, 0, 1'b1, 9, 11);
        next_cycle();

        set_ren(0, 8, 9, 1'b1, 8, 12);
        flush = 1'b1;
        settle();
        chk1("pre-flush r8", 0, 1'b1, 10);
        chk2("pre-flush r9", 0, 1'b1, 11);
        next_cycle();

        set_ren(0, 8, 9, 1'b0, 0, 0);
        set_ren(1, 4, 6, 1'b0, 0, 0);
        settle();
        chk1("flush r8", 0, 1'b0, 0);
        chk2("flush r9", 0, 1'b0, 0);
        chk1("flush r4", 1, 1'b0, 0);
        chk2("flush r6", 1, 1'b0, 0);
        next_cycle();

        // Mixed traffic on a small register window, checked by the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 3) != 0)
                    set_ren(i, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                            1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
                            int'($urandom_range(0, 2**T - 1)));
            end
            for (int j = 0; j < R; j++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int a;
                    a = int'($urandom_range(0, 12));
                    set_ret(j, a, ($urandom_range(0, 1) != 0) ? int'(m_tag[a])
                                                              : int'($urandom_range(0, 2**T - 1)));
                end
            end
            flush = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 79) == 0);
            next_cycle();
            rst = 1'b0;
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
